// File: rtl/loader_pkg.sv
// loader_pkg: shared command/response codes and FSM state encoding for uart_loader
// Optional build macro LOADER_CHECKSUM_EN adds the CSUM state.
package loader_pkg;
    localparam logic [7:0] CMD_WRITE = 8'hA5;
    localparam logic [7:0] CMD_RUN   = 8'h5A;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE,
        RESP
`ifdef LOADER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;
endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: byte stream, response and memory-write signals of uart_loader
// master: loader side (drives tx/mem/cpu_run/busy); slave: environment side.
interface uart_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        busy;
    modport master (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, mem_we, mem_addr, mem_wdata, cpu_run, busy
    );
    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, mem_we, mem_addr, mem_wdata, cpu_run, busy
    );
endinterface

// File: rtl/uart_loader.sv
// uart_loader: UART byte-frame loader writing 32-bit words to memory and releasing the CPU
// Ports: clk, rst (async, active-high); bus (uart_loader_if.master): rx_valid/rx_data in,
// tx_ready in, tx_valid/tx_data out, mem_we/mem_addr/mem_wdata out, cpu_run out, busy out.
// Build macro LOADER_CHECKSUM_EN: expect an XOR checksum byte after the data bytes.
module uart_loader
    import loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic          clk,
    input logic          rst,
    uart_loader_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t      r_state, w_next;
    logic [1:0]  r_cnt;
    logic [TW-1:0] r_to;
    logic [31:0] r_addr_sh, r_data_sh, r_mem_addr, r_mem_wdata;
    logic [7:0]  r_tx_data;
    logic        r_cpu_run;
    logic        w_tout, w_count, w_tx_load, w_commit;
    logic [7:0]  w_tx_val;
    logic [31:0] w_data_nx, w_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign w_tout  = r_to == TW'(TIMEOUT_CYCLES - 1);
    assign w_count = r_state == ADDR || r_state == DATA
`ifdef LOADER_CHECKSUM_EN
                     || r_state == CSUM
`endif
                     ;

    // Data word with the incoming byte merged in; in the 9-byte frame this is the full word on the last byte.
    always_comb begin
        w_data_nx = r_data_sh;
        w_data_nx[{r_cnt, 3'b000} +: 8] = bus.rx_data;
    end

`ifdef LOADER_CHECKSUM_EN
    assign w_wdata = r_data_sh;
`else
    assign w_wdata = w_data_nx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_tx_load = 1'b0;
        w_tx_val  = ACK;
        w_commit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_WRITE) begin
                        w_next = ADDR;
                    end else begin
                        w_next    = RESP;
                        w_tx_load = 1'b1;
                        w_tx_val  = bus.rx_data == CMD_RUN ? ACK : NAK;
                    end
                end
            end
            ADDR: begin
                if (bus.rx_valid) w_next = r_cnt == 2'd3 ? DATA : ADDR;
                else if (w_tout)  w_next = IDLE;
            end
            DATA: begin
                if (bus.rx_valid) begin
                    if (r_cnt == 2'd3) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next = CSUM;
`else
                        w_next   = WRITE;
                        w_commit = 1'b1;
`endif
                    end
                end else if (w_tout) begin
                    w_next = IDLE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == r_csum) begin
                        w_next   = WRITE;
                        w_commit = 1'b1;
                    end else begin
                        w_next    = RESP;
                        w_tx_load = 1'b1;
                        w_tx_val  = NAK;
                    end
                end else if (w_tout) begin
                    w_next = IDLE;
                end
            end
`endif
            WRITE: begin
                w_next    = RESP;
                w_tx_load = 1'b1;
            end
            RESP: begin
                if (bus.tx_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_to        <= '0;
            r_addr_sh   <= '0;
            r_data_sh   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_tx_data   <= '0;
            r_cpu_run   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_cnt <= r_state == IDLE ? 2'd0 :
                     (bus.rx_valid && (r_state == ADDR || r_state == DATA)) ? r_cnt + 2'd1 : r_cnt;
            r_to  <= (bus.rx_valid || !w_count) ? '0 : r_to + TW'(1);
            if (r_state == ADDR && bus.rx_valid) r_addr_sh[{r_cnt, 3'b000} +: 8] <= bus.rx_data;
            if (r_state == DATA && bus.rx_valid) r_data_sh <= w_data_nx;
            // Memory-facing registers change only on a complete, accepted frame.
            if (w_commit) begin
                r_mem_addr  <= r_addr_sh;
                r_mem_wdata <= w_wdata;
            end
            if (w_tx_load) r_tx_data <= w_tx_val;
            if (r_state == IDLE && bus.rx_valid && bus.rx_data == CMD_RUN) r_cpu_run <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_state == IDLE ? 8'd0 :
                      (bus.rx_valid && (r_state == ADDR || r_state == DATA)) ? r_csum ^ bus.rx_data : r_csum;
`endif
        end
    end

    assign bus.tx_valid  = r_state == RESP;
    assign bus.tx_data   = r_tx_data;
    assign bus.mem_we    = r_state == WRITE;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_run   = r_cpu_run;
    assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed self-checking bench for uart_loader
module tb_uart_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int tv_cnt = 0;
    int we0, tv0;

    uart_loader_if bus();

    uart_loader #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we) we_cnt <= we_cnt + 1;
        if (bus.tx_valid) tv_cnt <= tv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] x;
        x = 8'h00;
        send(CMD_WRITE);
        for (int i = 0; i < 4; i++) begin
            send(a[8*i +: 8]);
            x ^= a[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            send(d[8*i +: 8]);
            x ^= d[8*i +: 8];
        end
`ifdef LOADER_CHECKSUM_EN
        send(x);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_cpu_run"}, 32'(bus.cpu_run), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        frame(32'h0000_0010, 32'hDEAD_BEEF);
        chk("w1_we", 32'(bus.mem_we), 32'd1);
        chk("w1_addr", bus.mem_addr, 32'h0000_0010);
        chk("w1_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("w1_we_drop", 32'(bus.mem_we), 32'd0);
        chk("w1_we_cnt", 32'(we_cnt), 32'd1);
        chk("w1_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("w1_tx_data", 32'(bus.tx_data), 32'h06);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        chk("w1_tx_done", 32'(bus.tx_valid), 32'd0);
        chk("w1_idle", 32'(bus.busy), 32'd0);
        bus.tx_ready = 1'b0;

        send(CMD_RUN);
        chk("run_flag", 32'(bus.cpu_run), 32'd1);
        chk("run_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("run_tx_data", 32'(bus.tx_data), 32'h06);
        for (int i = 0; i < 20; i++) begin
            bus.rx_valid = (i == 5);
            bus.rx_data  = CMD_WRITE;
            @(negedge clk);
            chk("resp_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, 8'h06});
        end
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        chk("resp_drop_busy", 32'(bus.busy), 32'd0);
        chk("resp_done", 32'(bus.tx_valid), 32'd0);

        we0 = we_cnt;
        send(8'h33);
        chk("nak_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("nak_tx_data", 32'(bus.tx_data), 32'h15);
        @(negedge clk);
        chk("nak_busy", 32'(bus.busy), 32'd0);
        chk("nak_no_we", 32'(we_cnt), 32'(we0));

        tv0 = tv_cnt;
        send(CMD_WRITE);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        repeat (40) @(negedge clk);
        chk("to_wait_busy", 32'(bus.busy), 32'd1);
        repeat (20) @(negedge clk);
        chk("to_idle", 32'(bus.busy), 32'd0);
        chk("to_no_tx", 32'(tv_cnt), 32'(tv0));
        chk("to_no_we", 32'(we_cnt), 32'(we0));
        chk("to_addr_kept", bus.mem_addr, 32'h0000_0010);
        chk("to_wdata_kept", bus.mem_wdata, 32'hDEAD_BEEF);
        frame(32'h0000_0020, 32'h1234_5678);
        chk("w2_we", 32'(bus.mem_we), 32'd1);
        chk("w2_addr", bus.mem_addr, 32'h0000_0020);
        chk("w2_wdata", bus.mem_wdata, 32'h1234_5678);
        @(negedge clk);
        chk("w2_tx_data", 32'(bus.tx_data), 32'h06);
        chk("w2_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("w2_run_sticky", 32'(bus.cpu_run), 32'd1);
        @(negedge clk);
        chk("w2_idle", 32'(bus.busy), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        bus.tx_ready = 1'b0;
        we0 = we_cnt;
        send(CMD_WRITE);
        send(8'h30); send(8'h00); send(8'h00); send(8'h00);
        send(8'h0D); send(8'hF0); send(8'hFE); send(8'hCA);
        send(8'h30 ^ 8'h0D ^ 8'hF0 ^ 8'hFE ^ 8'hCA ^ 8'hFF);
        chk("csum_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("csum_nak", 32'(bus.tx_data), 32'h15);
        @(negedge clk);
        chk("csum_no_we", 32'(we_cnt), 32'(we0));
        chk("csum_addr_kept", bus.mem_addr, 32'h0000_0020);
        bus.tx_ready = 1'b1;
        @(negedge clk);
`endif

        send(CMD_WRITE);
        send(8'h40); send(8'h00); send(8'h00); send(8'h00);
        send(8'hAA); send(8'hBB);
        chk("mid_data_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
